ms_ff_bank: RTL



---
 rtl/ms_ff_bank.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ms_ff_bank.sv
// ---------------------------------------------------------------------------
// ms_ff_bank
//   Bank of WIDTH master-slave flip-flops with a shared run-time mode that
//   selects SR, JK, D or T next-state behaviour for every bit.
//   The master stage captures at the rising clock edge.
//   The slave stage (q) and the change indicator update at the following
//   falling edge, so q lags the capturing rising edge by half a cycle.
//
// Parameters
//   WIDTH      number of flip-flop bits (1..32)
//   RESET_VAL  value loaded into master and slave while reset_n is low
//
// Ports
//   clk      clock: master captures on rise, slave updates on fall
//   reset_n  asynchronous active-low reset
//   mode     2'b00 SR, 2'b01 JK, 2'b10 D, 2'b11 T
//   en       capture enable, sampled at the rising edge
//   a        per-bit S / J / D / T operand
//   b        per-bit R / K operand (ignored in D and T modes)
//   err_clr  clears err, sampled at the rising edge
//   q        slave state
//   q_       bitwise complement of q
//   err      sticky per-bit flag: SR mode saw S=R=1 while enabled
//   changed  per-bit: q changed at the most recent falling edge
// ---------------------------------------------------------------------------
module ms_ff_bank #(
    parameter int unsigned          WIDTH     = 4,
    parameter logic [WIDTH-1:0]     RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          mode,
    input  logic                en,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                err_clr,
    output logic [WIDTH-1:0]    q,
    output logic [WIDTH-1:0]    q_,
    output logic [WIDTH-1:0]    err,
    output logic [WIDTH-1:0]    changed
);

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } ff_mode_e;

    logic [WIDTH-1:0] master_q;
    logic [WIDTH-1:0] master_d;
    logic [WIDTH-1:0] err_q;
    logic [WIDTH-1:0] err_d;
    logic [WIDTH-1:0] slave_q;
    logic [WIDTH-1:0] changed_q;
    logic [WIDTH-1:0] illegal_s;

    // Per-bit next state for the selected flip-flop type, from current q.
    // SR with S=R=1 holds; the error flag is handled separately.
    function automatic logic [WIDTH-1:0] ff_next(
        input ff_mode_e         m,
        input logic [WIDTH-1:0] op_a,
        input logic [WIDTH-1:0] op_b,
        input logic [WIDTH-1:0] cur
    );
        logic [WIDTH-1:0] res;
        case (m)
            MODE_SR: res = (op_a & ~op_b) | (~(op_a ^ op_b) & cur);
            MODE_JK: res = (op_a & ~cur) | (~op_b & cur);
            MODE_D:  res = op_a;
            MODE_T:  res = cur ^ op_a;
            default: res = cur;
        endcase
        return res;
    endfunction

    // Next master value and next sticky error flags.
    always_comb begin
        master_d  = slave_q;
        illegal_s = {WIDTH{1'b0}};
        if (en) begin
            master_d = ff_next(ff_mode_e'(mode), a, b, slave_q);
            if (ff_mode_e'(mode) == MODE_SR) begin
                illegal_s = a & b;
            end else begin
                illegal_s = {WIDTH{1'b0}};
            end
        end else begin
            master_d  = slave_q;
            illegal_s = {WIDTH{1'b0}};
        end
        // A newly detected illegal condition wins over a simultaneous clear.
        if (err_clr) begin
            err_d = illegal_s;
        end else begin
            err_d = err_q | illegal_s;
        end
    end

    // Master stage and error flags: capture at the rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            master_q <= RESET_VAL;
            err_q    <= {WIDTH{1'b0}};
        end else begin
            master_q <= master_d;
            err_q    <= err_d;
        end
    end

    // Slave stage and change indicator: transfer at the falling edge.
    // Reset held across the falling edge keeps the slave at RESET_VAL.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slave_q   <= RESET_VAL;
            changed_q <= {WIDTH{1'b0}};
        end else begin
            slave_q   <= master_q;
            changed_q <= slave_q ^ master_q;
        end
    end

    assign q       = slave_q;
    assign q_      = ~slave_q;
    assign err     = err_q;
    assign changed = changed_q;

endmodule
